// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder
// -----------------
// Multi-cycle WIDTH-bit adder/subtractor. A CHUNK-bit ripple stage is reused
// NCHUNK times; the carry between chunks lives in a register, so the final
// {cout, sum} equals that of a single WIDTH-bit ripple-carry adder.
//
// Subtraction is a + ~b + ~cin: the operand and the borrow-in are inverted at
// the accepting edge, and the same add path handles both modes. For
// subtraction, cout = 1 means "no borrow".
//
// Handshake: start is sampled only in IDLE or DONE. busy is high from the
// cycle after an accepted start until the result is written. done pulses
// for exactly one cycle, the first cycle in DONE. sum/cout/overflow are held
// from done until the next accepted start. A start seen during RUN is
// ignored.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : request pulse (honoured in IDLE / DONE only)
//   mode     : 0 = add (a+b+cin), 1 = subtract (a-b-cin)
//   a, b     : WIDTH-bit operands, sampled at the accepting edge only
//   cin      : carry-in (add) or borrow-in (sub)
//   busy     : operation in progress
//   done     : one-cycle result-valid pulse
//   sum      : WIDTH-bit result
//   cout     : raw carry out of the MSB
//   overflow : two's-complement signed overflow of the full-width result
module chunked_seq_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   // NCHUNK is derived from WIDTH and CHUNK and is not meant to be overridden.
   localparam int NCHUNK = WIDTH / CHUNK;
   // The index needs at least one bit, even when NCHUNK == 1.
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // state is kept as a plain named register so that checkers can probe it.
   state_t            state;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  opb;    // already inverted for subtraction
   logic              carry;  // inter-chunk carry (carry-in for chunk idx)
   logic [IDXW-1:0]   idx;

   // Combinational chunk slice and CHUNK-bit ripple stage
   logic [CHUNK-1:0]  a_chunk;
   logic [CHUNK-1:0]  b_chunk;
   logic [CHUNK:0]    csum;
   logic              last_chunk;

   always_comb begin
      a_chunk    = opa[idx*CHUNK +: CHUNK];
      b_chunk    = opb[idx*CHUNK +: CHUNK];
      csum       = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
      last_chunk = (idx == IDXW'(NCHUNK - 1));
   end

   // Control, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         opa      <= '0;
         opb      <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // done is high only for the first DONE cycle.
               done <= 1'b0;
               if (start) begin
                  opa   <= a;
                  opb   <= mode ? ~b : b;
                  carry <= mode ? ~cin : cin;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               sum[idx*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
               carry                   <= csum[CHUNK];
               if (last_chunk) begin
                  // csum[CHUNK-1] is the MSB of the full-width result here.
                  cout     <= csum[CHUNK];
                  overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                              (csum[CHUNK-1] != opa[WIDTH-1]);
                  idx      <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder: three instances
// (CHUNK = 16, 1, 64 with WIDTH = 64) and hand-computed expected results.
module tb_chunked_seq_adder;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        mode;
   logic        cin;
   logic [63:0] a;
   logic [63:0] b;

   logic        start16, start1, start64;
   logic        busy16, busy1, busy64;
   logic        done16, done1, done64;
   logic [63:0] sum16, sum1, sum64;
   logic        cout16, cout1, cout64;
   logic        ovf16, ovf1, ovf64;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   chunked_seq_adder #(.WIDTH(64), .CHUNK(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .a(a), .b(b),
      .cin(cin), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
      .overflow(ovf16)
   );

   chunked_seq_adder #(.WIDTH(64), .CHUNK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .a(a), .b(b),
      .cin(cin), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
      .overflow(ovf1)
   );

   chunked_seq_adder #(.WIDTH(64), .CHUNK(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .start(start64), .mode(mode), .a(a), .b(b),
      .cin(cin), .busy(busy64), .done(done64), .sum(sum64), .cout(cout64),
      .overflow(ovf64)
   );

   // comparison point
   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver helpers
   task automatic set_start(input int inst, input logic v);
      case (inst)
         1:       start1  = v;
         64:      start64 = v;
         default: start16 = v;
      endcase
   endtask

   task automatic get(input int inst, output logic [63:0] s, output logic co,
                      output logic ov, output logic bz, output logic dn);
      case (inst)
         1:       begin s = sum1;  co = cout1;  ov = ovf1;  bz = busy1;  dn = done1;  end
         64:      begin s = sum64; co = cout64; ov = ovf64; bz = busy64; dn = done64; end
         default: begin s = sum16; co = cout16; ov = ovf16; bz = busy16; dn = done16; end
      endcase
   endtask

   // Drives operands and a one-cycle start; returns #1 after the accepting edge.
   task automatic launch(input int inst, input logic m, input logic [63:0] av,
                         input logic [63:0] bv, input logic c);
      @(negedge clk);
      mode = m; a = av; b = bv; cin = c;
      set_start(inst, 1'b1);
      @(posedge clk);
      #1;
      set_start(inst, 1'b0);
   endtask

   // Counts edges (accepting edge = 1) until done is seen, bounded.
   task automatic wait_done(input int inst, input int c0, output int cyc);
      logic [63:0] s;
      logic co, ov, bz, dn;
      cyc = c0;
      get(inst, s, co, ov, bz, dn);
      while (!dn && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         get(inst, s, co, ov, bz, dn);
      end
   endtask

   task automatic run_vec(input int inst, input string tag, input logic m,
                          input logic [63:0] av, input logic [63:0] bv, input logic c,
                          input logic [63:0] exp_sum, input logic exp_co,
                          input logic exp_ov, input int exp_lat);
      int cyc;
      logic [63:0] s;
      logic co, ov, bz, dn;
      launch(inst, m, av, bv, c);
      wait_done(inst, 1, cyc);
      get(inst, s, co, ov, bz, dn);
      check({tag, " latency"},  65'(cyc), 65'(exp_lat));
      check({tag, " sum"},      {1'b0, s}, {1'b0, exp_sum});
      check({tag, " cout"},     65'(co), 65'(exp_co));
      check({tag, " overflow"}, 65'(ov), 65'(exp_ov));
      check({tag, " busy/done"}, 65'({bz, dn}), 65'(2'b01));
   endtask

   // directed sequence
   initial begin
      logic [63:0] s;
      logic co, ov, bz, dn;
      int cyc;
      logic saw_done;

      rst_n = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
      start16 = 1'b0; start1 = 1'b0; start64 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      get(16, s, co, ov, bz, dn);
      check("reset16 sum", {1'b0, s}, 65'd0);
      check("reset16 flags", 65'({bz, dn, co, ov}), 65'd0);
      get(1, s, co, ov, bz, dn);
      check("reset1 flags", 65'({bz, dn, co, ov}), 65'd0);
      get(64, s, co, ov, bz, dn);
      check("reset64 flags", 65'({bz, dn, co, ov}), 65'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic add with a carry into chunk 2, plus latency
      run_vec(16, "add32", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
              64'h0000_0001_0000_0000, 1'b0, 1'b0, 5);
      // done is a single-cycle pulse; results are held afterwards
      @(posedge clk);
      #1;
      get(16, s, co, ov, bz, dn);
      check("add32 done pulse", 65'({bz, dn}), 65'd0);
      check("add32 held sum", {1'b0, s}, {1'b0, 64'h0000_0001_0000_0000});

      // carry across every chunk boundary
      run_vec(16, "wrap1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 5);
      run_vec(16, "wrapc", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 5);
      // signed overflow
      run_vec(16, "ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 5);
      // subtraction
      run_vec(16, "sub57", 1'b1, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5);
      run_vec(16, "sub75", 1'b1, 64'd7, 64'd5, 1'b1, 64'h1, 1'b1, 1'b0, 5);
      run_vec(16, "subovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 5);

      // start during RUN is ignored
      launch(16, 1'b0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0);
      @(posedge clk);
      #1;
      get(16, s, co, ov, bz, dn);
      check("hs busy", 65'({bz, dn}), 65'(2'b10));
      @(negedge clk);
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; mode = 1'b1;
      start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      wait_done(16, 3, cyc);
      get(16, s, co, ov, bz, dn);
      check("hs latency", 65'(cyc), 65'd5);
      check("hs sum", {1'b0, s}, {1'b0, 64'h0002_0002_0002_0002});
      check("hs cout", 65'(co), 65'd0);

      // back-to-back: start in the done cycle
      launch(16, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      get(16, s, co, ov, bz, dn);
      check("b2b accepted", 65'({bz, dn}), 65'(2'b10));
      wait_done(16, 1, cyc);
      get(16, s, co, ov, bz, dn);
      check("b2b latency", 65'(cyc), 65'd5);
      check("b2b sum", {1'b0, s}, {1'b0, 64'h2222_2222_2222_2211});
      check("b2b cout/ovf", 65'({co, ov}), 65'd0);

      // reset during the third RUN cycle
      launch(16, 1'b0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      get(16, s, co, ov, bz, dn);
      check("mid busy", 65'({bz, dn}), 65'(2'b10));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      get(16, s, co, ov, bz, dn);
      check("mid rst sum", {1'b0, s}, 65'd0);
      check("mid rst flags", 65'({bz, dn, co, ov}), 65'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done16 | busy16;
      end
      check("post rst idle", 65'(saw_done), 65'd0);
      check("post rst sum", {1'b0, sum16}, 65'd0);

      // CHUNK = 1 (65-cycle latency)
      run_vec(1, "c1 wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 65);
      run_vec(1, "c1 sub", 1'b1, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 65);
      run_vec(1, "c1 mix", 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0, 65);
      run_vec(1, "c1 ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 65);

      // CHUNK = 64 (2-cycle latency)
      run_vec(64, "c64 wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 2);
      run_vec(64, "c64 sub", 1'b1, 64'd7, 64'd5, 1'b1, 64'h1, 1'b1, 1'b0, 2);
      run_vec(64, "c64 subovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 2);

      // final report
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
